// File: rtl/regfile_access_arbiter_if.sv
// Requester-side bus of the register file access arbiter: request, grant and read response.
interface regfile_access_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic [DW-1:0]      resp_rdata;
    logic               err;
    logic               lock_timeout;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, err, lock_timeout
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, err, lock_timeout
    );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one register file port among NREQ requesters, with bus lock.
// Define REGARB_WPROT_EN to make address 0 write-protected (writes dropped, err pulsed).
module regfile_access_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 3,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_access_arbiter_if.slave  bus,
    output logic                     rf_en,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_addr,
    output logic [DW-1:0]            rf_wdata,
    input  logic [DW-1:0]            rf_rdata
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   idle_cnt;

    logic            xfer;
    logic [IW-1:0]   gnt_idx;
    logic            sel_we;
    logic            sel_lock;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            in_range;
    logic            wprot;

    // Grant: owner only while locked, otherwise first valid after rr_ptr
    always_comb begin
        int unsigned idx;
        idx     = 0;
        xfer    = 1'b0;
        gnt_idx = '0;
        if (!rst) begin
            if (state == LOCKED) begin
                xfer    = bus.req_valid[owner];
                gnt_idx = owner;
            end else begin
                for (int k = 1; k <= int'(NREQ); k++) begin
                    idx = (32'(rr_ptr) + 32'(k)) % NREQ;
                    if (!xfer && bus.req_valid[IW'(idx)]) begin
                        xfer    = 1'b1;
                        gnt_idx = IW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        sel_we    = bus.req_we[gnt_idx];
        sel_lock  = bus.req_lock[gnt_idx];
        sel_addr  = bus.req_addr[32'(gnt_idx)*AW +: AW];
        sel_wdata = bus.req_wdata[32'(gnt_idx)*DW +: DW];
        in_range  = 32'(sel_addr) < DEPTH;
`ifdef REGARB_WPROT_EN
        wprot     = sel_we && (sel_addr == '0);
`else
        wprot     = 1'b0;
`endif
    end

    // Register file strobe is suppressed for out-of-range or protected accesses
    always_comb begin
        bus.req_ready = xfer ? (NREQ'(1) << gnt_idx) : '0;
        rf_en         = xfer && in_range && !wprot;
        rf_we         = rf_en && sel_we;
        rf_addr       = xfer ? sel_addr : '0;
        rf_wdata      = (xfer && sel_we) ? sel_wdata : '0;
    end

    // Arbitration state, lock ownership and registered responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ARB;
            rr_ptr           <= IW'(NREQ - 1);
            owner            <= '0;
            idle_cnt         <= '0;
            bus.resp_valid   <= '0;
            bus.resp_rdata   <= '0;
            bus.err          <= 1'b0;
            bus.lock_timeout <= 1'b0;
        end else begin
            bus.resp_valid   <= '0;
            bus.err          <= 1'b0;
            bus.lock_timeout <= 1'b0;
            if (xfer) begin
                rr_ptr   <= gnt_idx;
                owner    <= gnt_idx;
                idle_cnt <= '0;
                state    <= sel_lock ? LOCKED : ARB;
                bus.err  <= !in_range || wprot;
                if (!sel_we) begin
                    bus.resp_valid <= NREQ'(1) << gnt_idx;
                    bus.resp_rdata <= in_range ? rf_rdata : '0;
                end
            end else if (state == LOCKED) begin
                // Owner stays idle: release once the counter has saturated
                if (idle_cnt == CW'(LOCK_MAX)) begin
                    state            <= ARB;
                    idle_cnt         <= '0;
                    bus.lock_timeout <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_regfile_access_arbiter;
    localparam int unsigned NREQ     = 2;
    localparam int unsigned DW       = 32;
    localparam int unsigned AW       = 3;
    localparam int unsigned DEPTH    = 6;
    localparam int unsigned LOCK_MAX = 15;
`ifdef REGARB_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_access_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    logic          rf_en;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;

    regfile_access_arbiter #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .rf_en   (rf_en),
        .rf_we   (rf_we),
        .rf_addr (rf_addr),
        .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata)
    );

    // Register file storage seen by the DUT; unimplemented addresses read as garbage
    logic [DW-1:0] rf_mem [8] = '{32'd1, 32'd5, 32'd3, 32'h11, 32'h22, 32'd7, 32'd0, 32'd0};
    assign rf_rdata = (32'(rf_addr) < DEPTH) ? rf_mem[rf_addr] : 32'hDEAD_BEEF;
    always @(posedge clk) if (rf_en && rf_we) rf_mem[rf_addr] <= rf_wdata;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0]   m_mem [DEPTH] = '{32'd1, 32'd5, 32'd3, 32'h11, 32'h22, 32'd7};
    int              m_ptr, m_owner, m_idle, g, ga;
    bit              m_locked, gwe, glock, oor, prot;
    logic [DW-1:0]   gwd;
    logic [NREQ-1:0] m_rv;
    logic [DW-1:0]   m_rdata;
    bit              m_err, m_to;
    logic [NREQ-1:0] e_ready;
    bit              e_en;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                           input int a, input logic [DW-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_we[i]             = we;
        bus.req_lock[i]           = lk;
        bus.req_addr[i*AW +: AW]  = AW'(a);
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    // Evaluate the model for the current cycle and compare every DUT output
    task automatic eval();
        @(negedge clk);
        g = -1;
        if (rst) begin
            m_ptr = NREQ - 1; m_locked = 0; m_owner = 0; m_idle = 0;
            m_rv = '0; m_rdata = '0; m_err = 0; m_to = 0;
        end else if (m_locked) begin
            if (bus.req_valid[m_owner]) g = m_owner;
        end else begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
        end
        ga    = (g >= 0) ? int'(bus.req_addr[g*AW +: AW]) : 0;
        gwe   = (g >= 0) && bus.req_we[g];
        glock = (g >= 0) && bus.req_lock[g];
        gwd   = (g >= 0) ? bus.req_wdata[g*DW +: DW] : '0;
        oor   = ga >= int'(DEPTH);
        prot  = WPROT && gwe && ga == 0;
        e_ready = (g >= 0) ? NREQ'(1) << g : '0;
        e_en    = (g >= 0) && !oor && !prot;

        chk("req_ready", 64'(bus.req_ready), 64'(e_ready));
        chk("rf_en", 64'(rf_en), 64'(e_en));
        if (e_en) begin
            chk("rf_we", 64'(rf_we), 64'(gwe));
            chk("rf_addr", 64'(rf_addr), 64'(ga));
            if (gwe) chk("rf_wdata", 64'(rf_wdata), 64'(gwd));
        end
        if (rst) begin
            chk("rst_rf_we", 64'(rf_we), 64'd0);
            chk("rst_rf_addr", 64'(rf_addr), 64'd0);
            chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        end
        chk("resp_valid", 64'(bus.resp_valid), 64'(m_rv));
        if (m_rv != '0 || rst) chk("resp_rdata", 64'(bus.resp_rdata), 64'(m_rdata));
        chk("err", 64'(bus.err), 64'(m_err));
        chk("lock_timeout", 64'(bus.lock_timeout), 64'(m_to));
    endtask

    // Advance the model across the clock edge, then release inputs for the next cycle
    task automatic adv();
        @(posedge clk);
        if (!rst) begin
            m_rv = '0; m_err = 0; m_to = 0;
            if (g >= 0) begin
                m_ptr = g;
                if (!gwe) begin
                    m_rv    = NREQ'(1) << g;
                    m_rdata = oor ? '0 : m_mem[ga];
                end else if (!oor && !prot) begin
                    m_mem[ga] = gwd;
                end
                m_err    = oor || prot;
                m_locked = glock;
                m_owner  = g;
                m_idle   = 0;
            end else if (m_locked) begin
                if (m_idle == int'(LOCK_MAX)) begin
                    m_locked = 0; m_idle = 0; m_to = 1;
                end else begin
                    m_idle++;
                end
            end
        end
        #1;
    endtask

    task automatic cyc();
        eval();
        adv();
    endtask

    initial begin
        rst = 1'b1;
        clear_all();
        eval();
        chk("lit_rst_ready", 64'(bus.req_ready), 64'd0);
        chk("lit_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        adv();
        cyc();
        rst = 1'b0;

        // Single read after reset: requester 0 wins first, latency 1
        set_req(0, 1, 0, 0, 2, '0);
        eval();
        chk("lit_first_ready", 64'(bus.req_ready), 64'h1);
        chk("lit_first_rf_addr", 64'(rf_addr), 64'h2);
        adv();
        clear_all();
        eval();
        chk("lit_first_resp_valid", 64'(bus.resp_valid), 64'h1);
        chk("lit_first_rdata", 64'(bus.resp_rdata), 64'h3);
        adv();

        // Both continuously valid: pointer sits at 0, so grants go 1,0,1,0...
        set_req(0, 1, 0, 0, 1, '0);
        set_req(1, 1, 0, 0, 5, '0);
        for (int k = 0; k < 6; k++) begin
            eval();
            chk("lit_alt_ready", 64'(bus.req_ready), (k % 2 == 0) ? 64'h2 : 64'h1);
            if (k > 0) chk("lit_alt_rdata", 64'(bus.resp_rdata), (k % 2 == 1) ? 64'h7 : 64'h5);
            adv();
        end
        clear_all();
        cyc();

        // Locked write by requester 1 shuts out requester 0 until unlocked read
        set_req(1, 1, 1, 1, 4, 32'h0000_ABCD);
        set_req(0, 1, 0, 0, 3, '0);
        eval();
        chk("lit_lock_ready", 64'(bus.req_ready), 64'h2);
        adv();
        set_req(1, 0, 0, 0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            eval();
            chk("lit_locked_ready", 64'(bus.req_ready), 64'h0);
            adv();
        end
        set_req(1, 1, 0, 0, 4, '0);
        eval();
        chk("lit_unlock_ready", 64'(bus.req_ready), 64'h2);
        adv();
        set_req(1, 0, 0, 0, 0, '0);
        eval();
        chk("lit_unlock_rdata", 64'(bus.resp_rdata), 64'h0000_ABCD);
        chk("lit_after_unlock_ready", 64'(bus.req_ready), 64'h1);
        adv();
        clear_all();
        cyc();

        // Lock timeout: 15 idle cycles saturate the counter, release on the next idle one
        set_req(0, 1, 0, 1, 1, '0);
        eval();
        chk("lit_to_lock_ready", 64'(bus.req_ready), 64'h1);
        adv();
        set_req(0, 0, 0, 0, 0, '0);
        set_req(1, 1, 0, 0, 2, '0);
        for (int k = 1; k <= 16; k++) begin
            eval();
            chk("lit_to_wait_ready", 64'(bus.req_ready), 64'h0);
            chk("lit_to_wait_pulse", 64'(bus.lock_timeout), 64'h0);
            adv();
        end
        eval();
        chk("lit_to_pulse", 64'(bus.lock_timeout), 64'h1);
        chk("lit_to_next_ready", 64'(bus.req_ready), 64'h2);
        adv();
        clear_all();
        cyc();

        // Owner returns exactly when the counter is saturated: transfer wins, no timeout
        set_req(0, 1, 0, 1, 1, '0);
        cyc();
        set_req(0, 0, 0, 0, 0, '0);
        set_req(1, 1, 0, 0, 5, '0);
        for (int k = 1; k <= 15; k++) cyc();
        set_req(0, 1, 0, 0, 2, '0);
        eval();
        chk("lit_sim_ready", 64'(bus.req_ready), 64'h1);
        adv();
        set_req(0, 0, 0, 0, 0, '0);
        eval();
        chk("lit_sim_no_timeout", 64'(bus.lock_timeout), 64'h0);
        chk("lit_sim_rdata", 64'(bus.resp_rdata), 64'h3);
        adv();
        clear_all();
        cyc();

        // Out-of-range read and write
        set_req(0, 1, 0, 0, 7, '0);
        eval();
        chk("lit_oor_rf_en", 64'(rf_en), 64'h0);
        adv();
        set_req(0, 1, 1, 0, 6, 32'h1234_5678);
        eval();
        chk("lit_oor_resp_valid", 64'(bus.resp_valid), 64'h1);
        chk("lit_oor_rdata", 64'(bus.resp_rdata), 64'h0);
        chk("lit_oor_err", 64'(bus.err), 64'h1);
        adv();
        clear_all();
        eval();
        chk("lit_oorw_err", 64'(bus.err), 64'h1);
        chk("lit_oorw_resp_valid", 64'(bus.resp_valid), 64'h0);
        adv();

        // Write of all-ones to address 0, then read it back
        set_req(1, 1, 1, 0, 0, 32'hFFFF_FFFF);
        eval();
        chk("lit_a0_rf_en", 64'(rf_en), WPROT ? 64'h0 : 64'h1);
        adv();
        clear_all();
        eval();
        chk("lit_a0_err", 64'(bus.err), WPROT ? 64'h1 : 64'h0);
        adv();
        set_req(1, 1, 0, 0, 0, '0);
        cyc();
        clear_all();
        eval();
        chk("lit_a0_rdata", 64'(bus.resp_rdata), WPROT ? 64'h1 : 64'hFFFF_FFFF);
        adv();

        // Random traffic: dense phase, then sparse phase to exercise lock timeouts
        for (int p = 0; p < 2; p++) begin
            for (int n = 0; n < 500; n++) begin
                if (rst) rst = 1'b0;
                else if ($urandom_range(0, 199) == 0) rst = 1'b1;
                for (int i = 0; i < int'(NREQ); i++)
                    set_req(i, $urandom_range(0, 99) < ((p == 0) ? 70 : 12),
                            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                            int'($urandom_range(0, 7)),
                            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
                cyc();
            end
        end
        rst = 1'b0;
        clear_all();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
